// File: rtl/bitonic_merge_network_p_pkg.sv
// bitonic_merge_network_p_pkg: shared sizing helpers for the bitonic merger
package bitonic_merge_network_p_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
    return r;
  endfunction
  function automatic int stages(input int p);
    return clog2(p) + 1;
  endfunction
  function automatic int rec_base(input int j, input int w);
    return j * w;
  endfunction
endpackage

// File: rtl/bitonic_merge_network_p_if.sv
// bitonic_merge_network_p_if: tuple-in / merged-tuple-out bundle with stall and sideband
interface bitonic_merge_network_p_if #(
  parameter int DATA_WIDTH = 32,
  parameter int P = 4,
  parameter int SIDE_WIDTH = 2 * DATA_WIDTH
);
  logic i_stall;
  logic i_valid;
  logic i_desc;
  logic i_switch_output;
  logic [SIDE_WIDTH-1:0] i_top_tuple;
  logic [P*DATA_WIDTH-1:0] i_elems_a;
  logic [P*DATA_WIDTH-1:0] i_elems_b;
  logic o_valid;
  logic [P*DATA_WIDTH-1:0] o_elems_lo;
  logic [P*DATA_WIDTH-1:0] o_elems_hi;
  logic o_switch_output;
  logic [SIDE_WIDTH-1:0] o_top_tuple;
  modport master (
    output i_stall, i_valid, i_desc, i_switch_output, i_top_tuple, i_elems_a, i_elems_b,
    input  o_valid, o_elems_lo, o_elems_hi, o_switch_output, o_top_tuple
  );
  modport slave (
    input  i_stall, i_valid, i_desc, i_switch_output, i_top_tuple, i_elems_a, i_elems_b,
    output o_valid, o_elems_lo, o_elems_hi, o_switch_output, o_top_tuple
  );
endinterface

// File: rtl/bitonic_merge_network_p_cas.sv
// bitonic_cas: combinational compare-exchange; equal records keep their order
module bitonic_cas #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);
  logic swap;
  assign swap = y < x;
  assign lo = swap ? y : x;
  assign hi = swap ? x : y;
endmodule

// File: rtl/bitonic_merge_network_p.sv
// bitonic_merge_network_p: pipelined merge of two ascending P-record tuples into 2P sorted records
module bitonic_merge_network_p
  import bitonic_merge_network_p_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int P = 4,
  parameter int SIDE_WIDTH = 2 * DATA_WIDTH
) (
  input logic i_clk,
  input logic i_rst,
  bitonic_merge_network_p_if.slave bus
);
  localparam int S = stages(P);
  localparam int N = 2 * P;
  localparam int DW = DATA_WIDTH;
  logic [N*DW-1:0] q [S];
  logic v [S];
  logic d [S];
  logic sw [S];
  logic [SIDE_WIDTH-1:0] tt [S];
  for (genvar k = 0; k < S; k++) begin : g_st
    localparam int D = P >> k;
    logic [N*DW-1:0] x, y, z;
    logic v_in, d_in, sw_in;
    logic [SIDE_WIDTH-1:0] tt_in;
    if (k == 0) begin : g_src
      // a ascending followed by b reversed forms the bitonic input
      for (genvar i = 0; i < P; i++) begin : g_w
        assign x[rec_base(i, DW) +: DW] = bus.i_elems_a[rec_base(i, DW) +: DW];
        assign x[rec_base(P + i, DW) +: DW] = bus.i_elems_b[rec_base(P - 1 - i, DW) +: DW];
      end
      assign v_in = bus.i_valid;
      assign d_in = bus.i_desc;
      assign sw_in = bus.i_switch_output;
      assign tt_in = bus.i_top_tuple;
    end else begin : g_src
      assign x = q[k-1];
      assign v_in = v[k-1];
      assign d_in = d[k-1];
      assign sw_in = sw[k-1];
      assign tt_in = tt[k-1];
    end
    for (genvar b = 0; b < N / (2 * D); b++) begin : g_blk
      for (genvar o = 0; o < D; o++) begin : g_off
        localparam int L = b * 2 * D + o;
        bitonic_cas #(.DATA_WIDTH(DW)) u_cas (
          .x (x[rec_base(L, DW) +: DW]),
          .y (x[rec_base(L + D, DW) +: DW]),
          .lo(y[rec_base(L, DW) +: DW]),
          .hi(y[rec_base(L + D, DW) +: DW])
        );
      end
    end
    // descending order is a pure record reversal folded into the last register
    for (genvar j = 0; j < N; j++) begin : g_rev
      assign z[rec_base(j, DW) +: DW] = (k == S - 1 && d_in) ? y[rec_base(N - 1 - j, DW) +: DW]
                                                             : y[rec_base(j, DW) +: DW];
    end
    always_ff @(posedge i_clk)
      if (i_rst) begin
        q[k] <= '0;
        v[k] <= 1'b0;
        d[k] <= 1'b0;
        sw[k] <= 1'b0;
        tt[k] <= '0;
      end else if (!bus.i_stall) begin
        q[k] <= z;
        v[k] <= v_in;
        d[k] <= d_in;
        sw[k] <= sw_in;
        tt[k] <= tt_in;
      end
  end
  assign bus.o_valid = v[S-1];
  assign bus.o_elems_lo = q[S-1][P*DW-1:0];
  assign bus.o_elems_hi = q[S-1][N*DW-1:P*DW];
  assign bus.o_switch_output = sw[S-1];
  assign bus.o_top_tuple = tt[S-1];
endmodule

// File: tb/tb_bitonic_merge_network_p.sv
// tb_bitonic_merge_network_p: directed P=4 vectors plus randomized P=1,2,8 against a sort-based model
module tb_bitonic_merge_network_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic desc;
    logic sw;
    logic [15:0] top;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;
  vec_t tbl [5];

  logic rst4;
  bitonic_merge_network_p_if #(.DATA_WIDTH(8), .P(4), .SIDE_WIDTH(16)) d_if ();
  bitonic_merge_network_p #(.DATA_WIDTH(8), .P(4), .SIDE_WIDTH(16)) dut4 (
    .i_clk(clk), .i_rst(rst4), .bus(d_if.slave)
  );

  task automatic apply(input vec_t t);
    d_if.i_valid = 1'b1;
    d_if.i_desc = t.desc;
    d_if.i_switch_output = t.sw;
    d_if.i_top_tuple = t.top;
    d_if.i_elems_a = t.a;
    d_if.i_elems_b = t.b;
  endtask

  task automatic expect_out(input vec_t t, input string nm);
    chk({nm, " valid"}, 64'(d_if.o_valid), 64'(1));
    chk({nm, " lo"}, 64'(d_if.o_elems_lo), 64'(t.lo));
    chk({nm, " hi"}, 64'(d_if.o_elems_hi), 64'(t.hi));
    chk({nm, " switch"}, 64'(d_if.o_switch_output), 64'(t.sw));
    chk({nm, " top"}, 64'(d_if.o_top_tuple), 64'(t.top));
  endtask

  task automatic expect_zero(input string nm);
    chk({nm, " valid"}, 64'(d_if.o_valid), 64'(0));
    chk({nm, " lo"}, 64'(d_if.o_elems_lo), 64'(0));
    chk({nm, " hi"}, 64'(d_if.o_elems_hi), 64'(0));
    chk({nm, " switch"}, 64'(d_if.o_switch_output), 64'(0));
    chk({nm, " top"}, 64'(d_if.o_top_tuple), 64'(0));
  endtask

  initial begin
    tbl[0] = '{32'h09060401, 32'h08070302, 1'b0, 1'b1, 16'h1111, 32'h04030201, 32'h09080706};
    tbl[1] = '{32'hFFFF0000, 32'hFFFFFF00, 1'b0, 1'b0, 16'h2222, 32'hFF000000, 32'hFFFFFFFF};
    tbl[2] = '{32'h09060401, 32'h08070302, 1'b1, 1'b1, 16'h3333, 32'h06070809, 32'h01020304};
    tbl[3] = '{32'h08070605, 32'h04030201, 1'b0, 1'b0, 16'hA5C3, 32'h04030201, 32'h08070605};
    tbl[4] = '{32'h281E140A, 32'h281E140A, 1'b1, 1'b1, 16'hBEEF, 32'h1E1E2828, 32'h0A0A1414};
    rst4 = 1'b1;
    d_if.i_stall = 1'b0;
    d_if.i_valid = 1'b1;
    d_if.i_desc = 1'b0;
    for (int r = 0; r < 2; r++) begin
      d_if.i_switch_output = 1'b1;
      d_if.i_top_tuple = 16'($urandom());
      d_if.i_elems_a = $urandom();
      d_if.i_elems_b = $urandom();
      @(posedge clk); #1;
      expect_zero($sformatf("in reset %0d", r));
    end
    rst4 = 1'b0;
    d_if.i_valid = 1'b0;
    d_if.i_switch_output = 1'b0;
    d_if.i_top_tuple = '0;
    d_if.i_elems_a = '0;
    d_if.i_elems_b = '0;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      expect_zero($sformatf("after release %0d", r));
    end
    for (int n = 0; n < 5; n++) begin
      apply(tbl[n]);
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1;
        if (k == 1) d_if.i_valid = 1'b0;
        if (k < 3) chk($sformatf("vec%0d early valid %0d", n, k), 64'(d_if.o_valid), 64'(0));
        else expect_out(tbl[n], $sformatf("vec%0d", n));
      end
    end
    apply(tbl[0]);
    @(posedge clk); #1;
    chk("stall e1 valid", 64'(d_if.o_valid), 64'(0));
    apply(tbl[1]);
    @(posedge clk); #1;
    chk("stall e2 valid", 64'(d_if.o_valid), 64'(0));
    apply(tbl[2]);
    d_if.i_stall = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      chk($sformatf("frozen %0d valid", r), 64'(d_if.o_valid), 64'(0));
    end
    d_if.i_stall = 1'b0;
    @(posedge clk); #1;
    d_if.i_valid = 1'b0;
    expect_out(tbl[0], "stall T0");
    @(posedge clk); #1;
    expect_out(tbl[1], "stall T1");
    @(posedge clk); #1;
    expect_out(tbl[2], "stall T2");
    @(posedge clk); #1;
    chk("stall drain valid", 64'(d_if.o_valid), 64'(0));
    apply(tbl[3]);
    @(posedge clk); #1;
    apply(tbl[4]);
    @(posedge clk); #1;
    apply(tbl[0]);
    @(posedge clk); #1;
    expect_out(tbl[3], "full pipe");
    rst4 = 1'b1;
    d_if.i_stall = 1'b1;
    @(posedge clk); #1;
    expect_zero("reset over stall");
    rst4 = 1'b0;
    d_if.i_stall = 1'b0;
    d_if.i_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      chk($sformatf("flushed %0d valid", r), 64'(d_if.o_valid), 64'(0));
    end
    done_cnt++;
  end

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int PP = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    localparam int SS = $clog2(PP) + 1;
    localparam int W = PP * 8;
    logic rst;
    bitonic_merge_network_p_if #(.DATA_WIDTH(8), .P(PP), .SIDE_WIDTH(16)) r_if ();
    bitonic_merge_network_p #(.DATA_WIDTH(8), .P(PP), .SIDE_WIDTH(16)) dut (
      .i_clk(clk), .i_rst(rst), .bus(r_if.slave)
    );
    logic mv [SS];
    logic [W-1:0] mlo [SS];
    logic [W-1:0] mhi [SS];
    logic msw [SS];
    logic [15:0] mtop [SS];
    initial begin
      int aq[$], bq[$], mq[$];
      int mx;
      logic stall, valid, desc, sw;
      logic [15:0] top;
      logic [W-1:0] a, b, elo, ehi;
      for (int it = 0; it < 10000; it++) begin
        rst = (it < 2);
        stall = ($urandom_range(0, 9) == 0);
        valid = ($urandom_range(0, 9) < 7);
        if (it >= 5000 && it < 5000 + SS) begin
          stall = 1'b0;
          valid = 1'b1;
        end
        if (it == 5000 + SS) begin
          rst = 1'b1;
          stall = 1'b1;
        end
        mx = ($urandom_range(0, 3) == 0) ? 3 : 255;
        aq.delete();
        bq.delete();
        for (int j = 0; j < PP; j++) begin
          aq.push_back(int'($urandom_range(0, mx)));
          bq.push_back(int'($urandom_range(0, mx)));
        end
        aq.sort();
        bq.sort();
        for (int j = 0; j < PP; j++) begin
          a[j*8 +: 8] = 8'(aq[j]);
          b[j*8 +: 8] = 8'(bq[j]);
        end
        desc = 1'($urandom());
        sw = 1'($urandom());
        top = 16'($urandom());
        mq = {aq, bq};
        mq.sort();
        if (desc) mq.reverse();
        for (int j = 0; j < PP; j++) begin
          elo[j*8 +: 8] = 8'(mq[j]);
          ehi[j*8 +: 8] = 8'(mq[PP + j]);
        end
        r_if.i_stall = stall;
        r_if.i_valid = valid;
        r_if.i_desc = desc;
        r_if.i_switch_output = sw;
        r_if.i_top_tuple = top;
        r_if.i_elems_a = a;
        r_if.i_elems_b = b;
        @(posedge clk);
        if (rst) begin
          for (int k = 0; k < SS; k++) begin
            mv[k] = 1'b0;
            mlo[k] = '0;
            mhi[k] = '0;
            msw[k] = 1'b0;
            mtop[k] = '0;
          end
        end else if (!stall) begin
          for (int k = SS - 1; k > 0; k--) begin
            mv[k] = mv[k-1];
            mlo[k] = mlo[k-1];
            mhi[k] = mhi[k-1];
            msw[k] = msw[k-1];
            mtop[k] = mtop[k-1];
          end
          mv[0] = valid;
          mlo[0] = elo;
          mhi[0] = ehi;
          msw[0] = sw;
          mtop[0] = top;
        end
        #1;
        chk($sformatf("P%0d it%0d valid", PP, it), 64'(r_if.o_valid), 64'(mv[SS-1]));
        if (mv[SS-1] || rst) begin
          chk($sformatf("P%0d it%0d lo", PP, it), 64'(r_if.o_elems_lo), 64'(mlo[SS-1]));
          chk($sformatf("P%0d it%0d hi", PP, it), 64'(r_if.o_elems_hi), 64'(mhi[SS-1]));
          chk($sformatf("P%0d it%0d switch", PP, it), 64'(r_if.o_switch_output), 64'(msw[SS-1]));
          chk($sformatf("P%0d it%0d top", PP, it), 64'(r_if.o_top_tuple), 64'(mtop[SS-1]));
        end
      end
      rst = 1'b0;
      r_if.i_valid = 1'b0;
      r_if.i_stall = 1'b0;
      done_cnt++;
    end
  end

  initial begin
    int t;
    t = 0;
    while (done_cnt < 4 && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt < 4) begin
      miscompares++;
      $display("FAIL timeout: %0d of 4 checkers finished, want 4", done_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bitonic_merge_network_p.md
# bitonic_merge_network_p

Parametrised, fully pipelined bitonic merger for the merge-tree datapath. It takes two tuples of P records each, both sorted ascending, and emits the 2P records sorted as a low half and a high half. It replaces the fixed two-record network at every merger width, adds a per-tuple descending mode, and carries valid plus sideband bits through the pipeline in lockstep with the data. A global stall freezes the whole pipe without losing anything.

## Interface
Parameters:
- DATA_WIDTH, 32: width of one record; comparison is unsigned on the full record.
- P, 4: records per input tuple; power of two, at least 1.
- SIDE_WIDTH, 2*DATA_WIDTH: width of the top-tuple sideband carried alongside the data.

Ports:
- i_clk, in, 1: the single clock.
- i_rst, in, 1: reset; synchronous and active-high.
- i_stall, in, 1: while high, every pipeline register, including valid, holds its value.
- i_valid, in, 1: the input tuples are meaningful this cycle.
- i_desc, in, 1: 0 = ascending output, 1 = descending output; latched per tuple.
- i_switch_output, in, 1: sideband bit, passed through.
- i_top_tuple, in, SIDE_WIDTH: sideband, passed through.
- i_elems_a, in, P*DATA_WIDTH: sorted ascending; record j sits at bits [j*DATA_WIDTH +: DATA_WIDTH].
- i_elems_b, in, P*DATA_WIDTH: sorted ascending; same packing.
- o_valid, out, 1: output tuple is meaningful.
- o_elems_lo, out, P*DATA_WIDTH: ranks 0..P-1 of the merged result.
- o_elems_hi, out, P*DATA_WIDTH: ranks P..2P-1 of the merged result.
- o_switch_output, out, 1: delayed copy of i_switch_output.
- o_top_tuple, out, SIDE_WIDTH: delayed copy of i_top_tuple.

## Operation
- Build a 2P-record bitonic sequence: a in ascending order, followed by b reversed. The reversal is wiring only.
- Apply S = log2(2P) = log2(P)+1 half-cleaner stages, one registered stage each.
  - Stage k (0..S-1) uses compare distance D = P >> k.
  - Within each block of 2D records, pair i with i+D: min goes to i, max to i+D.
  - Ties (equal records) are not swapped.
- After stage S-1 the sequence is ascending.
  - Rank r of the 2P-record sequence maps to o_elems_lo record r for r < P, and to o_elems_hi record r-P for r >= P.
- Descending mode (i_desc captured with the tuple):
  - o_elems_lo record j = rank 2P-1-j.
  - o_elems_hi record j = rank P-1-j.
  - The output register performs this reversal; no extra stage.
- valid, desc, switch_output and top_tuple travel in per-stage shadow registers, so the sideband always stays aligned with its data.
- Data registers load unconditionally when not stalled. Records with valid = 0 are don't-care but still shift, so bubbles propagate.
- Inputs where a or b is not sorted: the output is undefined but deterministic. This is not checked.

## Timing
- Latency is S cycles:
  - A tuple presented at edge t with i_stall = 0 appears at the outputs after edge t+S-1+1, i.e. S registered stages.
  - Example: P=4 gives S=3.
- Throughput is one tuple per non-stalled cycle.
- Stall:
  - With i_stall high at an edge, no register in any stage changes and the inputs are ignored.
  - Outputs hold their values, including o_valid.
  - There is no partial advance: stall is global, not per-stage.
- Reset:
  - With i_rst high at an edge, every stage register, valid, desc, sideband and output clears to 0. o_valid, o_elems_lo, o_elems_hi, o_switch_output and o_top_tuple all read 0 after that edge.
  - Reset dominates i_stall.
  - In-flight tuples are discarded.
  - The first tuple accepted after reset release emerges S cycles later. Until then, o_valid stays 0.
- P = 1: S = 1, a single compare-exchange, i.e. the legacy 2-record behaviour plus valid, reset and mode.

## Structure
- Shared package bonsai_merge_pkg:
  - function clog2.
  - localparam helpers STAGES(P) = clog2(P)+1.
  - Record-slice macros or functions for packed tuple indexing.
- Sub-module bitonic_cas: purely combinational, DATA_WIDTH parameter, inputs x and y, outputs lo and hi.
- Top level instantiates P bitonic_cas per stage via generate loops over stage, block and offset.
- One always block per stage register bank.

## Test plan
- Reset: hold i_rst 2 cycles with i_valid=1 and random data -> all outputs 0 during reset and for 3 cycles after release (P=4); o_valid first rises exactly 3 cycles after the first accepted valid tuple.
- Merge, P=4, DATA_WIDTH=8: a={1,4,6,9}, b={2,3,7,8}, desc=0 -> 3 cycles later o_valid=1, lo={1,2,3,4}, hi={6,7,8,9}, sideband equals the value presented with that tuple.
- Duplicates and extremes: a={0,0,255,255}, b={0,255,255,255} -> lo={0,0,0,255}, hi={255,255,255,255}.
- Descending: same a and b as the merge case with i_desc=1 -> lo={9,8,7,6}, hi={4,3,2,1}.
- Stall: feed tuples T0, T1, T2 back-to-back, raise i_stall for 2 cycles after T1 is accepted -> outputs and o_valid frozen for exactly 2 cycles; T0, T1, T2 emerge in order with no loss or duplication.
- Reset mid-operation with P=8 randomized run: assert i_rst with a full pipe and i_stall=1 -> o_valid=0 the next cycle; none of the in-flight tuples ever appears. The run then continues for 10k random sorted tuples per P in {1,2,8}, checked against a sort-based reference model.
